pwm_av_gpio_pio: RTL

Parametrised Avalon-MM general-purpose I/O slave. It supersedes the fixed 8-bit output-only LED port in the pwm_av system. It adds:
- configurable width and output reset value
- atomic set/clear of output bits
- a synchronised input port with per-bit edge capture
- a maskable level interrupt to the CPU

It sits on the system interconnect as a zero-wait-state slave. It drives LEDs and samples switches and buttons.

---
 rtl/pwm_av_gpio_pio_if.sv | 24 ++
 rtl/pwm_av_gpio_pio.sv | 104 ++++++++++
 2 files changed

// File: rtl/pwm_av_gpio_pio_if.sv
// Avalon-MM slave bus bundle for the GPIO PIO: zero-wait-state writes, combinational reads.
interface pwm_av_gpio_pio_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/pwm_av_gpio_pio.sv
// Parametrised Avalon-MM GPIO slave: output register with atomic set/clear, synchronised
// inputs with sticky per-bit edge capture, and a maskable level interrupt.
module pwm_av_gpio_pio #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned      EDGE_MODE   = 0,
  parameter int unsigned      SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  pwm_av_gpio_pio_if.slave     bus,
  output logic [WIDTH-1:0]     out_port,
  input  logic [WIDTH-1:0]     in_port,
  output logic                 irq
);

  localparam int unsigned     ArmW   = $clog2(SYNC_STAGES + 2);
  localparam logic [ArmW-1:0] ArmMax = ArmW'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [ArmW-1:0]  arm_q, arm_d;

  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] edges;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] clr;
  logic             we;
  logic             armed;
  logic [31:0]      rdata;
  logic             unused_wdata;

  assign cur   = sync_q[SYNC_STAGES-1];
  assign wdata = bus.writedata[WIDTH-1:0];
  assign we    = bus.chipselect & ~bus.write_n;
  assign armed = (arm_q == ArmMax);
  assign arm_d = armed ? arm_q : arm_q + ArmW'(1);

  // Upper write-data bits are architecturally ignored.
  assign unused_wdata = ^bus.writedata;

  always_comb begin
    case (EDGE_MODE)
      1:       edges = ~cur & prev_q;
      2:       edges = cur ^ prev_q;
      default: edges = cur & ~prev_q;
    endcase
  end

  always_comb begin
    out_d  = out_q;
    mask_d = mask_q;
    clr    = '0;
    if (we) begin
      case (bus.address)
        3'd0:    out_d  = wdata;
        3'd1:    mask_d = wdata;
        3'd2:    clr    = wdata;
        3'd4:    out_d  = out_q | wdata;
        3'd5:    out_d  = out_q & ~wdata;
        default: ;
      endcase
    end
    // Edge is OR-ed in after the clear so a coincident edge leaves the bit set.
    cap_d = (cap_q & ~clr) | (armed ? edges : '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= '0;
      out_q  <= RESET_VALUE;
      mask_q <= '0;
      cap_q  <= '0;
      arm_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
      prev_q <= cur;
      out_q  <= out_d;
      mask_q <= mask_d;
      cap_q  <= cap_d;
      arm_q  <= arm_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (bus.address)
      3'd0:    rdata[WIDTH-1:0] = cur;
      3'd1:    rdata[WIDTH-1:0] = mask_q;
      3'd2:    rdata[WIDTH-1:0] = cap_q;
      3'd3:    rdata[WIDTH-1:0] = out_q;
      default: rdata = '0;
    endcase
  end

  assign bus.readdata = rdata;
  assign out_port     = out_q;
  assign irq          = |(cap_q & mask_q);

endmodule
